// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs a one-outstanding req/ack
// handshake to instruction memory and feeds decode through a one-entry skid.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic        inst_ce,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  input  logic        id_ready
);

  localparam logic [1:0] BOOT    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        outV_q, outV_d;
  logic [31:0] outPc_q, outPc_d;
  logic [31:0] outInst_q, outInst_d;
  logic        skidV_q, skidV_d;
  logic [31:0] skidPc_q, skidPc_d;
  logic [31:0] skidInst_q, skidInst_d;

  logic xfer;
  logic accept;
  logic outFree;

  assign xfer    = outV_q & id_ready;
  assign accept  = (state_q == REQ) & inst_ack & ~redirect_valid;
  assign outFree = ~outV_q | xfer;

  // Output and skid staging: skid always drains ahead of a freshly accepted word.
  always_comb begin
    outV_d     = outV_q;
    outPc_d    = outPc_q;
    outInst_d  = outInst_q;
    skidV_d    = skidV_q;
    skidPc_d   = skidPc_q;
    skidInst_d = skidInst_q;
    if (redirect_valid) begin
      outV_d  = 1'b0;
      skidV_d = 1'b0;
    end else if (outFree) begin
      if (skidV_q) begin
        outV_d    = 1'b1;
        outPc_d   = skidPc_q;
        outInst_d = skidInst_q;
        skidV_d   = accept;
        if (accept) begin
          skidPc_d   = pc_q;
          skidInst_d = inst_rdata;
        end
      end else if (accept) begin
        outV_d    = 1'b1;
        outPc_d   = pc_q;
        outInst_d = inst_rdata;
      end else begin
        outV_d = 1'b0;
      end
    end else if (accept) begin
      skidV_d    = 1'b1;
      skidPc_d   = pc_q;
      skidInst_d = inst_rdata;
    end
  end

  // Sequencer: HOLD stops requesting while both buffer slots are full.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (redirect_valid) begin
          if (inst_ack) begin
            pc_d = redirect_pc;
          end else begin
            tgt_d   = redirect_pc;
            state_d = DISCARD;
          end
        end else if (inst_ack) begin
          pc_d = pc_q + 32'd4;
          if (outV_d & skidV_d) state_d = HOLD;
        end
      end
      DISCARD: begin
        if (redirect_valid) tgt_d = redirect_pc;
        if (inst_ack) begin
          pc_d    = redirect_valid ? redirect_pc : tgt_q;
          state_d = REQ;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = REQ;
        end else if (xfer & skidV_q) begin
          state_d = REQ;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      tgt_q      <= 32'd0;
      outV_q     <= 1'b0;
      outPc_q    <= 32'd0;
      outInst_q  <= 32'd0;
      skidV_q    <= 1'b0;
      skidPc_q   <= 32'd0;
      skidInst_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      outV_q     <= outV_d;
      outPc_q    <= outPc_d;
      outInst_q  <= outInst_d;
      skidV_q    <= skidV_d;
      skidPc_q   <= skidPc_d;
      skidInst_q <= skidInst_d;
    end
  end

  assign pc       = pc_q;
  assign inst_ce  = (state_q == REQ) | (state_q == DISCARD);
  assign id_valid = outV_q;
  assign id_pc    = outPc_q;
  assign id_inst  = outInst_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random traffic, checked
// against a queue-based model of the fetch pipeline.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic        inst_ce;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready;

  int checks   = 0;
  int failures = 0;

  // Model: in-order queue of at most two pending instructions plus fetch address.
  bit          mStarted;
  bit          mDiscard;
  logic [31:0] mPc;
  logic [31:0] mTgt;
  logic [63:0] mq[$];
  logic [31:0] mLastPc;
  logic [31:0] mLastInst;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc(pc), .inst_ce(inst_ce), .inst_ack(inst_ack), .inst_rdata(inst_rdata),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return {addr[15:0], ~addr[15:0]} ^ 32'h1357_9BDF ^ {addr[31:16], 16'h0};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll();
    logic expCe;
    expCe = mStarted && (mDiscard || mq.size() < 2);
    checkOutput("pc", pc, mPc);
    checkOutput("inst_ce", {31'd0, inst_ce}, {31'd0, expCe});
    checkOutput("id_valid", {31'd0, id_valid}, {31'd0, (mq.size() > 0)});
    checkOutput("id_pc", id_pc, mLastPc);
    checkOutput("id_inst", id_inst, mLastInst);
  endtask

  task automatic modelStep();
    bit ce;
    bit xfer;
    if (rst) begin
      mStarted = 0; mDiscard = 0; mPc = 32'h0; mTgt = 32'h0;
      mq.delete(); mLastPc = 32'h0; mLastInst = 32'h0;
      return;
    end
    if (!mStarted) begin
      mStarted = 1;
      if (redirect_valid) mq.delete();
      return;
    end
    ce   = mDiscard || mq.size() < 2;
    xfer = (mq.size() > 0) && id_ready;
    if (redirect_valid) begin
      mq.delete();
      if (mDiscard) begin
        if (inst_ack) begin mPc = redirect_pc; mDiscard = 0; end
        else mTgt = redirect_pc;
      end else if (ce) begin
        if (inst_ack) mPc = redirect_pc;
        else begin mTgt = redirect_pc; mDiscard = 1; end
      end else begin
        mPc = redirect_pc;
      end
    end else begin
      if (xfer) void'(mq.pop_front());
      if (mDiscard) begin
        if (inst_ack) begin mPc = mTgt; mDiscard = 0; end
      end else if (ce && inst_ack) begin
        mq.push_back({mPc, inst_rdata});
        mPc = mPc + 32'd4;
      end
    end
    if (mq.size() > 0) begin
      mLastPc   = mq[0][63:32];
      mLastInst = mq[0][31:0];
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rv, input logic [31:0] rpc,
                               input logic ack, input logic rdy);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ack       = ack;
    inst_rdata     = ack ? memWord(mPc) : $urandom();
    id_ready       = rdy;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll();
  endtask

  initial begin
    logic [31:0] tmp;
    logic        r, rv, ack, rdy;
    mStarted = 0; mDiscard = 0; mPc = 0; mTgt = 0; mLastPc = 0; mLastInst = 0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    inst_ack = 1'b0; inst_rdata = 32'h0; id_ready = 1'b0;

    // Reset then zero-wait streaming.
    applyStimulus(1, 0, 0, 1, 1);
    applyStimulus(1, 0, 0, 1, 1);
    checkOutput("reset_pc", pc, 32'h0);
    checkOutput("reset_ce", {31'd0, inst_ce}, 32'd0);
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 1, 1);

    // Decode stalls until both slots fill, then drains in order.
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 1, 1);

    // Three wait states per request.
    for (int i = 0; i < 24; i++) applyStimulus(0, 0, 0, (i % 4) == 3, 1);

    // Redirect on an ack cycle.
    applyStimulus(0, 1, 32'h100, 1, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 1);

    // Redirect while waiting, then re-redirect during discard.
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 1, 32'h200, 0, 1);
    applyStimulus(0, 1, 32'h300, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 1);

    // PC wrap past the top of the address space.
    applyStimulus(0, 1, 32'hFFFF_FFF8, 1, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 1);

    // Reset in the middle of a wait, with a late ack on the reset edge.
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      rv  = mStarted && ($urandom_range(0, 99) < 8);
      tmp = $urandom() & 32'hFFFF_FFFC;
      ack = ($urandom_range(0, 99) < 50);
      rdy = ($urandom_range(0, 99) < 70);
      applyStimulus(r, rv, tmp, ack, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer that owns the program counter and drives instruction memory through a variable-latency request/acknowledge handshake. It delivers fetched instructions in order to decode over a valid/ready interface with a one-entry skid buffer. It applies taken branch/jump redirects and discards wrong-path data. It replaces the free-running PC+4 counter in the fetch stage.

## Interface
- RESET_PC, 32'h0000_0000, fetch address loaded on reset
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_pc  in  32  redirect target (word aligned)
- pc  out  32  current fetch address to instruction memory
- inst_ce  out  1  instruction memory request/enable
- inst_ack  in  1  memory completes the request this cycle
- inst_rdata  in  32  instruction word, valid when inst_ack=1
- id_valid  out  1  instruction available to decode
- id_pc  out  32  address of the presented instruction
- id_inst  out  32  presented instruction word
- id_ready  in  1  decode accepts this cycle; transfer = id_valid & id_ready

## Operation
- At most one memory request is outstanding. While inst_ce=1, pc is held stable until an edge samples inst_ack=1. inst_ack may arrive in the first cycle of inst_ce.
- Storage: output stage (id_valid/id_pc/id_inst), skid entry (skid_v/skid_pc/skid_inst), redirect target register tgt.
- inst_ce = (state==REQ) | (state==DISCARD), decoded from registered state only.
- States:
  - BOOT: entered on reset; inst_ce=0; next edge goes to REQ.
  - REQ: inst_ce=1.
    - ack & !redirect: accept the word tagged with pc; pc <= pc+4. Go to HOLD if output and skid are both occupied after the edge; otherwise stay in REQ.
    - ack & redirect: drop the word; pc <= redirect_pc; stay in REQ.
    - !ack & redirect: tgt <= redirect_pc; go to DISCARD; pc unchanged.
  - DISCARD: inst_ce=1, pc unchanged.
    - redirect: tgt <= redirect_pc, so the latest redirect wins.
    - ack: drop the word; pc <= (redirect ? redirect_pc : tgt); go to REQ.
  - HOLD: inst_ce=0. When the skid drains into the output, go to REQ. On redirect: pc <= redirect_pc; go to REQ.
- Ordering (no loss, no duplication):
  - The output stage loads from the skid first, then from the accepted word.
  - The output loads when it is empty or transferring this edge.
  - An accepted word goes to the skid only if the output stays occupied or the skid is moving into it.
- Redirect flushes the output stage and the skid at the same edge (id_valid <= 0, skid_v <= 0), in every state.
- Priority: rst > redirect > ack/transfer.
- id_pc and id_inst change only on load; they hold value otherwise.
- pc+4 wraps modulo 2^32.

## Timing
- Reset values (edge with rst=1): state=BOOT, pc=RESET_PC, inst_ce=0, id_valid=0, id_pc=0, id_inst=0, skid_v=0, tgt=0.
- inst_ce first rises after the first edge with rst=0; it is sampled high from the following edge.
- Latency: a word accepted at edge N appears on id_valid/id_pc/id_inst after edge N, if the output was free.
- Throughput: with zero-wait memory and id_ready=1, one instruction per cycle.
- rst mid-request: aborts immediately. An inst_ack seen in BOOT is ignored; the memory is reset by the same rst.
- Redirect and transfer in the same cycle: the transfer completes (decode consumed the instruction), then the output clears.

## Test plan
- Reset, inst_ack tied 1, id_ready=1:
  - inst_ce rises one cycle after reset release.
  - pc steps 0,4,8,…
  - id_pc follows one cycle behind, with id_inst equal to the mem word for each address.
- id_ready=0 for 6 cycles, zero-wait memory:
  - output holds pc 0, skid holds 4, pc=8, state HOLD, inst_ce=0.
  - on id_ready=1: id_pc 0, then 4 on consecutive cycles, then fetch resumes at 8.
- inst_ack delayed 3 cycles per request:
  - pc and inst_ce held stable for 3 cycles.
  - exactly one id load per ack.
- redirect_valid with redirect_pc=0x100 on an ack cycle:
  - word dropped, id_valid=0 next cycle, next pc=0x100.
  - first delivered id_pc=0x100.
- Redirect to 0x200 while waiting for a delayed ack, then redirect to 0x300 during DISCARD:
  - old address held until ack; data dropped.
  - next pc=0x300; 0x200 never fetched.
- rst asserted mid-wait with a late inst_ack:
  - all outputs at reset values after the edge.
  - ack ignored; fetch restarts at RESET_PC.
